median_window_feeder: RTL and testbench

Upstream stage for the median core. It accepts an 8-bit sample stream over a valid/ready handshake and keeps an 8-entry sliding window in the core's register file by overwriting the oldest slot through the core's write port. After a fixed latency it captures the core's result and presents it on a valid/ready output stream. The core's `out_select` is driven elsewhere; this block only reads whatever result the core presents.

---
 rtl/median_feeder_pkg.sv | 24 ++
 rtl/feeder_lat_counter.sv | 35 +++
 rtl/median_window_feeder.sv | 159 +++++++++++++++
 tb/tb_median_window_feeder.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/median_feeder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : median_feeder_pkg
// Description : Shared widths and the state encoding for median_window_feeder
//               and its latency counter.
// Revision    : 1.0 - initial release
// ============================================================================
package median_feeder_pkg;

  localparam int DATA_W   = 8;
  localparam int WIN_SIZE = 8;
  localparam int ADDR_W   = 3;
  localparam int FILL_W   = 4;
  localparam int LAT_W    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } feeder_state_t;

endpackage : median_feeder_pkg
`default_nettype wire

// File: rtl/feeder_lat_counter.sv
`default_nettype none
// ============================================================================
// Module      : feeder_lat_counter
// Description : Loadable down-counter that measures the core's result latency.
//               o_done flags the last counted cycle (count == 1).
// Revision    : 1.0 - initial release
// ============================================================================
module feeder_lat_counter
  import median_feeder_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [LAT_W-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_done
);

  logic [LAT_W-1:0] r_cnt;

  // Load takes priority; otherwise count down while enabled, stopping at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = (r_cnt == LAT_W'(1));

endmodule : feeder_lat_counter
`default_nettype wire

// File: rtl/median_window_feeder.sv
`default_nettype none
// ============================================================================
// Module      : median_window_feeder
// Description : Feeds an 8-entry sliding sample window into the median core's
//               register file and returns the core's result on a valid/ready
//               stream. Optional macro MEDIAN_FEEDER_PRIME_EN: the first
//               sample after reset is replicated into all 8 slots so a result
//               follows immediately.
// Revision    : 1.0 - initial release
// ============================================================================
module median_window_feeder
  import median_feeder_pkg::*;
#(
  parameter int RESULT_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] core_data,
  output logic [ADDR_W-1:0] core_addr,
  output logic              core_wr_en,
  input  logic [DATA_W-1:0] core_result,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready
);

  localparam logic [LAT_W-1:0]  c_result_lat = LAT_W'(RESULT_LAT);
  localparam logic [FILL_W-1:0] c_win_full   = FILL_W'(WIN_SIZE);

  feeder_state_t     r_state;
  feeder_state_t     w_state_nxt;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [FILL_W-1:0] r_fill;
  logic [FILL_W-1:0] w_fill_inc;
  logic              w_accept;
  logic              w_lat_load;
  logic              w_lat_en;
  logic              w_lat_done;
  logic              w_capture;

  // Saturating window occupancy after one more sample.
  assign w_fill_inc = (r_fill == c_win_full) ? c_win_full : r_fill + 1'b1;

  // Held low while reset is active so upstream never sees a spurious ready.
  assign s_ready = (r_state == IDLE) && !rst;

  // The core only captures on the edge after our write strobe, so the latency
  // count starts once that strobe has dropped.
  assign w_lat_en = (r_state == WAIT) && !core_wr_en;

  feeder_lat_counter u_lat_counter (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_lat_load),
    .i_load_val (c_result_lat),
    .i_en       (w_lat_en),
    .o_done     (w_lat_done)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and per-cycle control strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_lat_load  = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (s_valid) begin
          w_accept   = 1'b1;
          w_lat_load = 1'b1;
`ifdef MEDIAN_FEEDER_PRIME_EN
          if (r_fill == '0) begin
            w_state_nxt = PRIME;
          end else
`endif
          if (w_fill_inc == c_win_full) begin
            w_state_nxt = WAIT;
          end
        end
      end
`ifdef MEDIAN_FEEDER_PRIME_EN
      PRIME: begin
        if (r_wr_ptr == ADDR_W'(WIN_SIZE - 1)) begin
          w_state_nxt = WAIT;
          w_lat_load  = 1'b1;
        end
      end
`endif
      WAIT: begin
        if (w_lat_done && !core_wr_en) begin
          w_capture   = 1'b1;
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (m_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Window write port, pointer/occupancy bookkeeping and result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_fill     <= '0;
      core_wr_en <= 1'b0;
      core_addr  <= '0;
      core_data  <= '0;
      m_data     <= '0;
      m_valid    <= 1'b0;
    end else begin
      core_wr_en <= 1'b0;
      if (w_accept) begin
        core_wr_en <= 1'b1;
        core_data  <= s_data;
        core_addr  <= r_wr_ptr;
        r_wr_ptr   <= r_wr_ptr + 1'b1;
        r_fill     <= w_fill_inc;
      end
`ifdef MEDIAN_FEEDER_PRIME_EN
      // Replicate the held sample into the remaining slots; the next real
      // sample overwrites slot 1 because slot 0 was written first.
      if (r_state == PRIME) begin
        core_wr_en <= 1'b1;
        core_addr  <= r_wr_ptr;
        if (r_wr_ptr == ADDR_W'(WIN_SIZE - 1)) begin
          r_wr_ptr <= ADDR_W'(1);
          r_fill   <= c_win_full;
        end else begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
        end
      end
`endif
      if (w_capture) begin
        m_data  <= core_result;
        m_valid <= 1'b1;
      end else if ((r_state == HOLD) && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule : median_window_feeder
`default_nettype wire

// File: tb/tb_median_window_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_median_window_feeder
// Description : Self-checking bench for median_window_feeder with a
//               behavioural median core and a sample-history reference model.
//               Honours MEDIAN_FEEDER_PRIME_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_median_window_feeder;

  localparam int RL = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] core_data;
  logic [2:0] core_addr;
  logic       core_wr_en;
  logic [7:0] core_result;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;

  median_window_feeder #(.RESULT_LAT(RL)) dut (
    .clk         (clk),
    .rst         (rst),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .core_data   (core_data),
    .core_addr   (core_addr),
    .core_wr_en  (core_wr_en),
    .core_result (core_result),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Single comparison point.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] med_of8(input logic [7:0] a [8]);
    int w[$];
    foreach (a[i]) w.push_back(int'(a[i]));
    w.sort();
    return 8'(w[4]);
  endfunction

  // ---------------- behavioural median core ----------------
  // Result is only trustworthy RL cycles after the write; before that the core
  // presents a deliberately wrong value.
  logic [7:0] core_mem [8] = '{default: 8'd0};
  logic [7:0] mem_tmp  [8];
  logic [7:0] core_med = 8'd0;
  int         age      = 1000;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (core_wr_en) begin
      mem_tmp = core_mem;
      mem_tmp[core_addr] = core_data;
      core_mem <= mem_tmp;
      core_med <= med_of8(mem_tmp);
      age      <= 0;
    end else if (age < 1000) begin
      age <= age + 1;
    end
  end

  assign core_result = (age >= RL - 1) ? core_med : ~core_med;

  // ---------------- reference model ----------------
  int hist[$];
  int wa_q[$];
  int wd_q[$];
  int med_q[$];
  int lat_q[$];
  int m_wptr   = 0;
  int accepted = 0;

  function automatic int median_last8();
    int w[$];
    for (int i = 0; i < 8; i++) w.push_back(hist[hist.size() - 8 + i]);
    w.sort();
    return w[4];
  endfunction

  task automatic model_accept(input int x);
    int nw;
    accepted++;
`ifdef MEDIAN_FEEDER_PRIME_EN
    if (hist.size() == 0) begin
      for (int i = 0; i < 8; i++) begin
        wa_q.push_back(i);
        wd_q.push_back(x);
        hist.push_back(x);
      end
      m_wptr = 1;
      nw = 8;
    end else
`endif
    begin
      wa_q.push_back(m_wptr);
      wd_q.push_back(x);
      hist.push_back(x);
      m_wptr = (m_wptr + 1) % 8;
      nw = 1;
    end
    if (hist.size() >= 8) begin
      med_q.push_back(median_last8());
      lat_q.push_back(cyc + 1 + nw + RL);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    wa_q.delete();
    wd_q.delete();
    med_q.delete();
    lat_q.delete();
    m_wptr = 0;
  endtask

  // ---------------- monitor (samples on the falling edge) ----------------
  logic       prev_mv   = 1'b0;
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = 8'd0;

  always @(negedge clk) begin
    if (rst) begin
      prev_mv   = 1'b0;
      prev_hold = 1'b0;
    end else begin
      if (core_wr_en) begin
        if (wa_q.size() == 0) begin
          check("wr_unexpected", core_wr_en, 0);
        end else begin
          check("wr_addr", core_addr, wa_q.pop_front());
          check("wr_data", core_data, wd_q.pop_front());
        end
      end
      if (m_valid) check("s_ready_while_pending", s_ready, 0);
      if (m_valid && !prev_mv) begin
        if (lat_q.size() == 0) check("m_valid_unexpected", m_valid, 0);
        else check("latency", cyc, lat_q.pop_front());
      end
      if (m_valid && prev_hold) check("hold_stable", m_data, prev_data);
      if (m_valid && m_ready) begin
        if (med_q.size() == 0) check("result_unexpected", m_valid, 0);
        else check("median", m_data, med_q.pop_front());
      end
      if (s_valid && s_ready) model_accept(int'(s_data));
      prev_mv   = m_valid;
      prev_hold = m_valid && !m_ready;
      prev_data = m_data;
    end
  end

  // Optional random backpressure.
  bit rand_mr = 1'b0;
  always @(posedge clk) begin
    #1;
    if (rand_mr) m_ready = ($urandom_range(0, 3) != 0);
  end

  // ---------------- stimulus helpers (called at posedge+1) ----------------
  task automatic send(input logic [7:0] x);
    bit ok = 1'b0;
    s_data  = x;
    s_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (s_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    if (!ok) check("send_timeout", ok, 1);
  endtask

  task automatic wait_out(input string tag, input logic [7:0] e);
    bit ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (m_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) check(tag, m_data, e);
    else check({tag, "_timeout"}, ok, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && med_q.size() != 0; k++) @(posedge clk);
    #1;
    check("drain_pending", med_q.size(), 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_s_ready"}, s_ready, 0);
    check({tag, "_core_wr_en"}, core_wr_en, 0);
    check({tag, "_core_addr"}, core_addr, 0);
    check({tag, "_core_data"}, core_data, 0);
    check({tag, "_m_valid"}, m_valid, 0);
    check({tag, "_m_data"}, m_data, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int acc0;
    bit ok;
    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = 8'd0;
    m_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("s_ready_after_reset", s_ready, 1);
    @(posedge clk);
    #1;

`ifdef MEDIAN_FEEDER_PRIME_EN
    send(8'd7);
    wait_out("prime_median", 8'd7);
    send(8'd200);
    wait_out("prime_slide", 8'd7);
`else
    for (int i = 1; i <= 8; i++) send(8'(i * 10));
    wait_out("fill_median", 8'd50);
    send(8'd90);
    wait_out("slide_median", 8'd60);
`endif
    // Continue to 17 samples in total: exercises the pointer wrap.
    for (int i = 0; i < 8; i++) send(8'($urandom_range(0, 255)));
    drain();

    // Backpressure: result held while upstream keeps offering a sample.
    m_ready = 1'b0;
    send(8'($urandom_range(0, 255)));
    s_data  = 8'($urandom_range(0, 255));
    s_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (m_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check("bp_result_seen", ok, 1);
    acc0 = accepted;
    repeat (5) begin
      @(negedge clk);
      check("bp_s_ready", s_ready, 0);
    end
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (s_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("bp_release", ok, 1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    repeat (RL + 6) @(posedge clk);
    #1;
    check("bp_one_accept", accepted - acc0, 1);
    drain();

    // Random traffic with random downstream stalls.
    rand_mr = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send(8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    rand_mr = 1'b0;
    @(posedge clk);
    #2;
    m_ready = 1'b1;
    drain();

    // Reset in the middle of the latency wait.
    send(8'($urandom_range(0, 255)));
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    check_reset_vals("mid_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) send(8'($urandom_range(0, 255)));
    drain();
    check("writes_retired", wa_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Absolute guard against a stuck run.
  initial begin
    #500000;
    $display("FAIL global_timeout: got 0, expected 1");
    $fatal(1, "timeout");
  end

endmodule : tb_median_window_feeder
`default_nettype wire
